parallel_to_serial_tx: RTL and testbench

Transmit-side serializer: accepts WIDTH-bit parallel symbols through a valid/ready handshake and, while `load_send` is high, shifts them out one bit per clock, back-to-back. When no symbol is waiting at a symbol boundary, it sends the idle pattern. It sits directly downstream of the symbol source and is driven by the `clock`/`reset`/`load_send` stimulus of the parallel-to-serial bench.

---
 rtl/pts_pkg.sv | 22 ++
 rtl/pts_shift_reg.sv | 48 ++++
 rtl/parallel_to_serial_tx.sv | 97 +++++++++
 tb/tb_parallel_to_serial_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pts_pkg.sv
// Shared definitions for the parallel-to-serial transmitter: state encoding,
// K28.5 comma constants and the default symbol width.
package pts_pkg;

  localparam int PTS_DEFAULT_WIDTH = 10;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  localparam logic [1:0] ST_RST_ENC   = 2'd0;
  localparam logic [1:0] ST_LOAD_ENC  = 2'd1;
  localparam logic [1:0] ST_SEND_ENC  = 2'd2;
  localparam logic [1:0] ST_DRAIN_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_RST   = ST_RST_ENC,
    ST_LOAD  = ST_LOAD_ENC,
    ST_SEND  = ST_SEND_ENC,
    ST_DRAIN = ST_DRAIN_ENC
  } pts_state_t;

endpackage

// File: rtl/pts_shift_reg.sv
// WIDTH-bit load/shift register with bit counter for the serializer.
// Bit order: LSB first, or MSB first when PTS_MSB_FIRST_EN is defined.
module pts_shift_reg
  import pts_pkg::*;
#(
  parameter int WIDTH = PTS_DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  output logic             o_bit,
  output logic             o_last_bit
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_shift_reg;
  logic [CW-1:0]    r_bit_cnt;

  // Zeros shift in, so after the final shift of a symbol the output bit is 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift_reg <= '0;
      r_bit_cnt   <= '0;
    end else if (i_load) begin
      r_shift_reg <= i_load_data;
      r_bit_cnt   <= '0;
    end else if (i_shift) begin
`ifdef PTS_MSB_FIRST_EN
      r_shift_reg <= {r_shift_reg[WIDTH-2:0], 1'b0};
`else
      r_shift_reg <= {1'b0, r_shift_reg[WIDTH-1:1]};
`endif
      r_bit_cnt   <= (r_bit_cnt == LAST_CNT) ? '0 : r_bit_cnt + 1'b1;
    end
  end

`ifdef PTS_MSB_FIRST_EN
  assign o_bit = r_shift_reg[WIDTH-1];
`else
  assign o_bit = r_shift_reg[0];
`endif
  assign o_last_bit = (r_bit_cnt == LAST_CNT);

endmodule

// File: rtl/parallel_to_serial_tx.sv
// Transmit serializer: valid/ready symbol intake, holding register and FSM.
// Define PTS_MSB_FIRST_EN to send bit WIDTH-1 first instead of bit 0.
module parallel_to_serial_tx
  import pts_pkg::*;
#(
  parameter int               WIDTH        = PTS_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_PATTERN = WIDTH'(K28_5_RDN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_send,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             symbol_start,
  output logic             busy,
  output pts_state_t       o_dbg_state
);

  // Handshake: a symbol transfers on a rising edge where data_valid and
  // data_ready are both high; data_ready never depends on data_valid.

  pts_state_t       r_state;
  logic [WIDTH-1:0] r_hold_reg;
  logic             r_hold_full;
  logic             r_symbol_start;
  logic             r_busy;

  logic             w_active;
  logic             w_last_bit;
  logic             w_bit;
  logic             w_boundary;
  logic             w_shift;
  logic             w_xfer;
  logic [WIDTH-1:0] w_load_data;

  assign w_active   = (r_state == ST_SEND) || (r_state == ST_DRAIN);
  assign w_boundary = load_send && ((r_state == ST_LOAD) || (w_active && w_last_bit));
  assign w_shift    = w_active && !w_boundary;
  assign data_ready = (r_state != ST_RST) && (!r_hold_full || w_boundary);
  assign w_xfer     = data_valid && data_ready;

  // An empty holding register at a boundary takes data_in directly when offered.
  assign w_load_data = r_hold_full ? r_hold_reg :
                       (data_valid ? data_in : IDLE_PATTERN);

  pts_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift_reg (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_boundary),
    .i_load_data(w_load_data),
    .i_shift    (w_shift),
    .o_bit      (w_bit),
    .o_last_bit (w_last_bit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_RST;
      r_hold_reg     <= '0;
      r_hold_full    <= 1'b0;
      r_symbol_start <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_symbol_start <= w_boundary;
      r_busy         <= w_boundary || (w_shift && !w_last_bit);

      if (w_boundary && r_hold_full) begin
        r_hold_full <= w_xfer;
        if (w_xfer) r_hold_reg <= data_in;
      end else if (w_xfer && !w_boundary) begin
        r_hold_reg  <= data_in;
        r_hold_full <= 1'b1;
      end

      case (r_state)
        ST_RST:   r_state <= ST_LOAD;
        ST_LOAD:  if (load_send) r_state <= ST_SEND;
        ST_SEND:  if (!load_send) r_state <= w_last_bit ? ST_LOAD : ST_DRAIN;
        ST_DRAIN: begin
          if (load_send)       r_state <= ST_SEND;
          else if (w_last_bit) r_state <= ST_LOAD;
        end
        default:  r_state <= ST_RST;
      endcase
    end
  end

  assign serial_out   = w_bit;
  assign symbol_start = r_symbol_start;
  assign busy         = r_busy;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// Scoreboard bench for parallel_to_serial_tx: directed symbols push expected
// bits into a queue, a negedge monitor pops and compares while busy is high.
module tb_parallel_to_serial_tx;
  import pts_pkg::*;

  localparam int W = 10;
  localparam logic [W-1:0] IDLE = 10'b0011111010;

  logic         clock;
  logic         reset;
  logic         load_send;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic         serial_out;
  logic         symbol_start;
  logic         busy;
  pts_state_t   dbg_state;

  logic [1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  parallel_to_serial_tx #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .load_send   (load_send),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .serial_out  (serial_out),
    .symbol_start(symbol_start),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected {symbol_start, serial_out} per transmitted bit.
  task automatic push_symbol(input logic [W-1:0] sym);
    for (int i = 0; i < W; i++) begin
`ifdef PTS_MSB_FIRST_EN
      exp_q.push_back({(i == 0), sym[W-1-i]});
`else
      exp_q.push_back({(i == 0), sym[i]});
`endif
    end
  endtask

  task automatic load_hold(input logic [W-1:0] sym);
    data_in    = sym;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (reset) begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", {symbol_start, serial_out}, 2'bxx);
        end else begin
          check("bit", {symbol_start, serial_out}, exp_q.pop_front());
        end
      end else begin
        check("idle_out", {symbol_start, serial_out}, 2'b00);
      end
    end
  end

  // driver
  initial begin
    reset      = 1'b0;
    load_send  = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;

    // Reset values and release
    @(negedge clock);
    check("rst_serial_out", serial_out, 1'b0);
    check("rst_symbol_start", symbol_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data_ready", data_ready, 1'b0);
    check("rst_state", dbg_state, ST_RST);
    tick();
    reset = 1'b1;
    @(negedge clock);
    check("rel_ready_rst", data_ready, 1'b0);
    tick();
    @(negedge clock);
    check("rel_ready_load", data_ready, 1'b1);
    check("rel_state_load", dbg_state, ST_LOAD);
    tick();

    // Single symbol 10'h2AA
    load_hold(10'h2AA);
    @(negedge clock);
    check("single_ready_full", data_ready, 1'b0);
    tick();
    push_symbol(10'h2AA);
    load_send = 1'b1;
    tick();
    load_send = 1'b0;
    repeat (12) tick();

    // Back-to-back 3FF, 001 then idle
    data_in    = 10'h3FF;
    data_valid = 1'b1;
    tick();
    data_in = 10'h001;
    @(negedge clock);
    check("b2b_ready_full_load", data_ready, 1'b0);
    tick();
    push_symbol(10'h3FF);
    push_symbol(10'h001);
    push_symbol(IDLE);
    load_send = 1'b1;
    tick();
    data_valid = 1'b0;
    @(negedge clock);
    check("b2b_ready_full_send", data_ready, 1'b0);
    tick();
    repeat (9) tick();
    @(negedge clock);
    check("b2b_ready_empty", data_ready, 1'b1);
    repeat (10) tick();
    load_send = 1'b0;
    repeat (12) tick();

    // Idle fill: three idle symbols back-to-back
    push_symbol(IDLE);
    push_symbol(IDLE);
    push_symbol(IDLE);
    load_send = 1'b1;
    tick();
    repeat (20) tick();
    load_send = 1'b0;
    repeat (12) tick();

    // Mid-symbol drop at bit 4
    load_hold(10'h0F5);
    push_symbol(10'h0F5);
    load_send = 1'b1;
    tick();
    repeat (4) tick();
    load_send = 1'b0;
    tick();
    @(negedge clock);
    check("drop_state_drain", dbg_state, ST_DRAIN);
    repeat (7) tick();
    @(negedge clock);
    check("drop_busy_done", busy, 1'b0);
    check("drop_state_load", dbg_state, ST_LOAD);
    tick();

    // Drop at bit 3, rise again at bit 6, next boundary reloads held symbol
    load_hold(10'h0F0);
    push_symbol(10'h0F0);
    push_symbol(10'h30C);
    load_send = 1'b1;
    tick();
    data_in    = 10'h30C;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (2) tick();
    load_send = 1'b0;
    repeat (3) tick();
    load_send = 1'b1;
    repeat (4) tick();
    load_send = 1'b0;
    repeat (12) tick();

    // Pass-through: handshake and boundary load on the same edge
    data_in    = 10'h200;
    data_valid = 1'b1;
    load_send  = 1'b1;
    push_symbol(10'h200);
    tick();
    data_valid = 1'b0;
    load_send  = 1'b0;
    @(negedge clock);
    check("pass_ready_empty", data_ready, 1'b1);
    repeat (12) tick();

    // Reset mid-symbol discards the in-flight and held symbols
    push_symbol(IDLE);
    load_send = 1'b1;
    tick();
    data_in    = 10'h155;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("abort_serial_out", serial_out, 1'b0);
    check("abort_symbol_start", symbol_start, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_data_ready", data_ready, 1'b0);
    exp_q.delete();
    load_send = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clock);
    check("abort_rel_ready_rst", data_ready, 1'b0);
    tick();
    @(negedge clock);
    check("abort_rel_ready", data_ready, 1'b1);
    tick();
    push_symbol(IDLE);
    load_send = 1'b1;
    tick();
    load_send = 1'b0;
    repeat (12) tick();

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
